// File: rtl/ws2812b_decoder.sv
// WS2812B one-wire receive decoder: recovers 24-bit GRB pixels from the
// pulse-width-coded line, tags each with its frame index and flags latch gaps.
module ws2812b_decoder #(
  parameter int unsigned BIT_THRESHOLD = 8,
  parameter int unsigned MIN_HIGH      = 2,
  parameter int unsigned MAX_HIGH      = 14,
  parameter int unsigned RESET_CYCLES  = 600,
  parameter int unsigned IDX_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_index,
  output logic             frame_done,
  output logic             error
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned SR_W  = PIX_W - 1;
  localparam int unsigned HC_W  = $clog2(MAX_HIGH + 2);
  localparam int unsigned LC_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned BC_W  = 5;

  localparam logic [HC_W-1:0] HC_SAT   = HC_W'(MAX_HIGH + 1);
  localparam logic [HC_W-1:0] HC_MIN   = HC_W'(MIN_HIGH);
  localparam logic [HC_W-1:0] HC_MAX   = HC_W'(MAX_HIGH);
  localparam logic [HC_W-1:0] HC_THR   = HC_W'(BIT_THRESHOLD);
  localparam logic [LC_W-1:0] LC_SAT   = LC_W'(RESET_CYCLES);
  localparam logic [LC_W-1:0] LC_LAST  = LC_W'(RESET_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(PIX_W - 1);

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    READY      = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } state_t;

  state_t state, state_d;

  logic din_m, din_s, din_q;
  logic rise, fall;

  logic [HC_W-1:0]  high_cnt, high_d;
  logic [LC_W-1:0]  low_cnt, low_d;
  logic [BC_W-1:0]  bit_cnt, bit_d;
  logic [SR_W-1:0]  shreg, shreg_d;
  logic [IDX_W-1:0] pix_cnt, pix_d;

  logic [23:0]      data_d;
  logic [IDX_W-1:0] index_d;
  logic             valid_d;
  logic             done_d;
  logic             error_d;
  logic             bit_val;

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_q <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
      din_q <= din_s;
    end
  end

  assign rise = din_s & ~din_q;
  assign fall = ~din_s & din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LATCH;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      pix_cnt     <= '0;
      pixel_data  <= '0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_d;
      high_cnt    <= high_d;
      low_cnt     <= low_d;
      bit_cnt     <= bit_d;
      shreg       <= shreg_d;
      pix_cnt     <= pix_d;
      pixel_data  <= data_d;
      pixel_index <= index_d;
      pixel_valid <= valid_d;
      frame_done  <= done_d;
      error       <= error_d;
    end
  end

  // Next-state and datapath; the 24th bit is published on the same edge it is sampled
  always_comb begin
    state_d = state;
    high_d  = high_cnt;
    low_d   = low_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    pix_d   = pix_cnt;
    data_d  = pixel_data;
    index_d = pixel_index;
    valid_d = 1'b0;
    done_d  = 1'b0;
    error_d = error;
    bit_val = (high_cnt >= HC_THR);

    case (state)
      WAIT_LATCH: begin
        if (din_s) begin
          low_d = '0;
        end else if (low_cnt >= LC_LAST) begin
          state_d = READY;
          low_d   = LC_SAT;
          bit_d   = '0;
          pix_d   = '0;
        end else begin
          low_d = low_cnt + LC_W'(1);
        end
      end

      READY: begin
        if (rise) begin
          state_d = HIGH;
          high_d  = HC_W'(1);
          if (bit_cnt == '0 && pix_cnt == '0) begin
            error_d = 1'b0;
          end
        end
      end

      HIGH: begin
        if (fall) begin
          if (high_cnt < HC_MIN || high_cnt > HC_MAX) begin
            error_d = 1'b1;
            state_d = WAIT_LATCH;
            low_d   = LC_W'(1);
            bit_d   = '0;
            shreg_d = '0;
          end else begin
            shreg_d = {shreg[SR_W-2:0], bit_val};
            state_d = LOW;
            low_d   = LC_W'(1);
            if (bit_cnt == BC_LAST) begin
              data_d  = {shreg, bit_val};
              index_d = pix_cnt;
              valid_d = 1'b1;
              pix_d   = pix_cnt + IDX_W'(1);
              bit_d   = '0;
            end else begin
              bit_d = bit_cnt + BC_W'(1);
            end
          end
        end else if (high_cnt != HC_SAT) begin
          high_d = high_cnt + HC_W'(1);
        end
      end

      LOW: begin
        if (rise) begin
          state_d = HIGH;
          high_d  = HC_W'(1);
        end else if (low_cnt >= LC_LAST) begin
          state_d = READY;
          low_d   = LC_SAT;
          done_d  = 1'b1;
          if (bit_cnt != '0) begin
            error_d = 1'b1;
          end
          bit_d   = '0;
          pix_d   = '0;
          shreg_d = '0;
        end else begin
          low_d = low_cnt + LC_W'(1);
        end
      end

      default: begin
        state_d = WAIT_LATCH;
      end
    endcase
  end

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Bench for ws2812b_decoder: drives WS2812B bit cells, scoreboards pixels and
// frame_done pulses, and hand-checks latency, error and reset corner cases.
module tb_ws2812b_decoder;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned LATCH = 620;

  logic             clk;
  logic             rst_n;
  logic             din;
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_index;
  logic             frame_done;
  logic             error;

  typedef struct {
    logic [23:0]      data;
    logic [IDX_W-1:0] idx;
  } pix_t;

  typedef struct {
    logic err;
    logic err_prev;
  } fd_t;

  typedef struct {
    logic [23:0]      data;
    logic [IDX_W-1:0] exp_idx;
  } vec_t;

  pix_t exp_pix[$];
  fd_t  exp_fd[$];
  pix_t mon_p;
  fd_t  mon_f;
  vec_t vecs[9];

  int   checks  = 0;
  int   passed  = 0;
  int   pv_seen = 0;
  int   fd_seen = 0;
  logic prev_err = 1'b0;

  ws2812b_decoder #(.IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Scoreboard: every pixel_valid / frame_done pops and compares an expectation
  always @(negedge clk) begin
    if (pixel_valid) begin
      pv_seen++;
      check("pixel_expected", 32'(exp_pix.size() != 0), 32'd1);
      check("pv_fd_exclusive", 32'(frame_done), 32'd0);
      if (exp_pix.size() != 0) begin
        mon_p = exp_pix.pop_front();
        check("pixel_data", 32'(pixel_data), 32'(mon_p.data));
        check("pixel_index", 32'(pixel_index), 32'(mon_p.idx));
      end
    end
    if (frame_done) begin
      fd_seen++;
      check("frame_done_expected", 32'(exp_fd.size() != 0), 32'd1);
      if (exp_fd.size() != 0) begin
        mon_f = exp_fd.pop_front();
        check("fd_error", 32'(error), 32'(mon_f.err));
        check("fd_error_prev", 32'(prev_err), 32'(mon_f.err_prev));
      end
    end
    prev_err = error;
  end

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    din = 1'b1;
    repeat (b ? 10 : 5) @(negedge clk);
    din = 1'b0;
    repeat (b ? 5 : 10) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] d);
    for (int i = 23; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic expect_pixel(input logic [23:0] d, input logic [IDX_W-1:0] idx);
    pix_t e;
    e.data = d;
    e.idx  = idx;
    exp_pix.push_back(e);
  endtask

  task automatic latch_expect(input logic err);
    fd_t f;
    f.err      = err;
    f.err_prev = 1'b0;
    exp_fd.push_back(f);
    idle(LATCH);
  endtask

  initial begin
    logic [23:0] d;

    vecs[0] = '{24'h123456, 3'd0};
    vecs[1] = '{24'hFEDCBA, 3'd1};
    vecs[2] = '{24'h000000, 3'd2};
    vecs[3] = '{24'hFFFFFF, 3'd3};
    vecs[4] = '{24'h800001, 3'd4};
    vecs[5] = '{24'h7FFFFE, 3'd5};
    vecs[6] = '{24'hAAAAAA, 3'd6};
    vecs[7] = '{24'h555555, 3'd7};
    vecs[8] = '{24'hC0FFEE, 3'd0};

    din   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pixel_data", 32'(pixel_data), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_pixel_index", 32'(pixel_index), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    idle(LATCH);

    // Single pixel with exact output latency on the last bit
    d = 24'hA5C3F0;
    expect_pixel(d, 3'd0);
    for (int i = 23; i >= 1; i--) send_bit(d[i]);
    din = 1'b1;
    repeat (5) @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    check("latency_edge1", 32'(pixel_valid), 32'd0);
    @(negedge clk);
    check("latency_edge2", 32'(pixel_valid), 32'd0);
    @(negedge clk);
    check("latency_edge3", 32'(pixel_valid), 32'd1);
    check("t1_error", 32'(error), 32'd0);
    repeat (7) @(negedge clk);
    check("t1_data_hold", 32'(pixel_data), 32'hA5C3F0);
    check("t1_valid_pulse", 32'(pixel_valid), 32'd0);
    latch_expect(1'b0);
    check("t1_pixel_count", 32'(pv_seen), 32'd1);

    // Multi-pixel frame from the table, index wraps mod 2^IDX_W
    for (int i = 0; i < 9; i++) begin
      expect_pixel(vecs[i].data, vecs[i].exp_idx);
      send_pixel(vecs[i].data);
    end
    latch_expect(1'b0);
    check("t2_scoreboard_empty", 32'(exp_pix.size()), 32'd0);
    check("t2_index_hold", 32'(pixel_index), 32'd0);
    check("t2_data_hold", 32'(pixel_data), 32'hC0FFEE);
    expect_pixel(24'h00FF00, 3'd0);
    send_pixel(24'h00FF00);
    latch_expect(1'b0);

    // Glitch mid-pixel: error, rest ignored until a full gap
    d = 24'h3C5A96;
    for (int i = 23; i >= 17; i--) send_bit(d[i]);
    din = 1'b1;
    @(negedge clk);
    din = 1'b0;
    repeat (5) @(negedge clk);
    check("t3_glitch_error", 32'(error), 32'd1);
    for (int i = 16; i >= 0; i--) send_bit(d[i]);
    idle(LATCH);
    check("t3_error_sticky", 32'(error), 32'd1);
    d = 24'h0F0F0F;
    expect_pixel(d, 3'd0);
    send_bit(d[23]);
    check("t3_error_cleared", 32'(error), 32'd0);
    for (int i = 22; i >= 0; i--) send_bit(d[i]);
    latch_expect(1'b0);

    // Partial pixel then latch: frame_done with error in the same cycle
    d = 24'hABC000;
    for (int i = 23; i >= 12; i--) send_bit(d[i]);
    latch_expect(1'b1);
    check("t4_error", 32'(error), 32'd1);
    check("t4_no_pixel", 32'(pv_seen), 32'd12);

    // Over-long high pulse: error on the falling edge, then WAIT_LATCH
    din = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_error_cleared_on_rise", 32'(error), 32'd0);
    din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_error_before_fall", 32'(error), 32'd0);
    @(negedge clk);
    check("t5_error_on_fall", 32'(error), 32'd1);
    idle(20);
    send_pixel(24'h111111);
    idle(LATCH);
    check("t5_error_sticky", 32'(error), 32'd1);
    check("t5_no_pixel", 32'(pv_seen), 32'd12);

    // Reset during bit 10 of a pixel
    expect_pixel(24'h3C3C3C, 3'd0);
    send_pixel(24'h3C3C3C);
    expect_pixel(24'hC3C3C3, 3'd1);
    send_pixel(24'hC3C3C3);
    d = 24'h96A5F1;
    for (int i = 23; i >= 15; i--) send_bit(d[i]);
    din = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pixel_data", 32'(pixel_data), 32'd0);
    check("t6_rst_pixel_index", 32'(pixel_index), 32'd0);
    check("t6_rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("t6_rst_frame_done", 32'(frame_done), 32'd0);
    check("t6_rst_error", 32'(error), 32'd0);
    @(negedge clk);
    din = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    send_pixel(24'h777777);
    idle(LATCH);
    check("t6_no_decode_after_reset", 32'(pv_seen), 32'd14);
    expect_pixel(24'h5A5A5A, 3'd0);
    send_pixel(24'h5A5A5A);
    latch_expect(1'b0);

    check("end_pixels_pending", 32'(exp_pix.size()), 32'd0);
    check("end_frames_pending", 32'(exp_fd.size()), 32'd0);
    check("end_pixel_count", 32'(pv_seen), 32'd15);
    check("end_frame_count", 32'(fd_seen), 32'd6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
